dtc_cali_src: RTL

Source side of the DTC calibration loop.
- Generates the DTC phase fraction from a fractional-N accumulator.
- Conditions the phase-detector sample into a DC-free error word.
- Sequences when the downstream RLS/LMS calibration engine may adapt.
- Sits between the PLL frequency-control word and the calibration engine. It drives the engine's X, ERR and EN inputs; the engine's sync_dly absorbs the PD-to-X alignment.

---
 rtl/dtc_cali_src_if.sv | 29 ++
 rtl/dtc_cali_src.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dtc_cali_src_if.sv
// Bus between the frequency-control / phase-detector side and the DTC calibration source.
// master: the upstream driver (PLL control + PD). slave: dtc_cali_src.
interface dtc_cali_src_if #(
    parameter int unsigned W   = 16,
    parameter int unsigned PDW = 12
);
    logic                  EN;
    logic [W-1:0]          FCW_FRAC;
    logic signed [PDW-1:0] PD;
    logic                  PD_VLD;
    logic                  BBPD_MODE;
    logic [15:0]           RUN_LEN;
    logic [W-1:0]          X_FRAC;
    logic                  OV;
    logic                  CALI_EN;
    logic signed [PDW:0]   ERR;
    logic                  ERR_VLD;
    logic [1:0]            STATE;

    modport master (
        output EN, FCW_FRAC, PD, PD_VLD, BBPD_MODE, RUN_LEN,
        input  X_FRAC, OV, CALI_EN, ERR, ERR_VLD, STATE
    );

    modport slave (
        input  EN, FCW_FRAC, PD, PD_VLD, BBPD_MODE, RUN_LEN,
        output X_FRAC, OV, CALI_EN, ERR, ERR_VLD, STATE
    );
endinterface

// File: rtl/dtc_cali_src.sv
// Source side of the DTC calibration loop: fractional-N phase accumulator, DC-free error
// conditioning of the PD sample, and the IDLE/SETTLE/RUN/HOLD adaptation sequencer.
module dtc_cali_src #(
    parameter int unsigned W          = 16,
    parameter int unsigned PDW        = 12,
    parameter int unsigned DC_SHIFT   = 6,
    parameter int unsigned SETTLE_CYC = 1024
) (
    input logic           CLK,
    input logic           NRST,
    dtc_cali_src_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RUN    = 2'd2,
        HOLD   = 2'd3
    } state_e;

    localparam int unsigned ACC_W       = PDW + DC_SHIFT + 1;
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);

    state_e                  state_q, state_d;
    logic [15:0]             cyc_q;
    logic [15:0]             smp_q;
    logic [15:0]             run_len_q;
    logic signed [ACC_W-1:0] dc_acc_q;
    logic [W-1:0]            x_q;
    logic                    ov_q;
    logic signed [PDW:0]     err_q;
    logic                    err_vld_q;

    logic signed [PDW-1:0]   pd_sel;
    logic signed [ACC_W-1:0] dc_full;
    logic signed [PDW:0]     dc;
    logic signed [PDW:0]     e;
    logic [W:0]              acc_sum;
    logic                    run_done;

    // Datapath: error select, DC estimate, DC-removed error and accumulator sum
    always_comb begin
        pd_sel = bus.PD;
        if (bus.BBPD_MODE) begin
            // PD==0 counts as positive
            pd_sel = bus.PD[PDW-1] ? '1 : PDW'(1);
        end
        dc_full  = dc_acc_q >>> DC_SHIFT;
        dc       = dc_full[PDW:0];
        e        = {pd_sel[PDW-1], pd_sel} - dc;
        acc_sum  = {1'b0, x_q} + {1'b0, bus.FCW_FRAC};
        run_done = bus.PD_VLD && (run_len_q != 16'd0) && (smp_q == run_len_q - 16'd1);
    end

    // Next-state decode; EN low wins over every other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = SETTLE;
            SETTLE:  if (cyc_q == SETTLE_LAST) state_d = RUN;
            RUN:     if (run_done) state_d = HOLD;
            HOLD:    state_d = HOLD;
            default: state_d = IDLE;
        endcase
        if (!bus.EN) state_d = IDLE;
    end

    // State register, counters, accumulator and registered outputs
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q   <= IDLE;
            cyc_q     <= '0;
            smp_q     <= '0;
            run_len_q <= '0;
            dc_acc_q  <= '0;
            x_q       <= '0;
            ov_q      <= 1'b0;
            err_q     <= '0;
            err_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_vld_q <= bus.PD_VLD && (state_d == RUN);

            if (bus.EN) begin
                {ov_q, x_q} <= acc_sum;
            end else begin
                ov_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    cyc_q    <= '0;
                    dc_acc_q <= '0;
                    err_q    <= '0;
                end
                SETTLE: begin
                    cyc_q <= cyc_q + 16'd1;
                    if (state_d == RUN) begin
                        smp_q     <= '0;
                        run_len_q <= bus.RUN_LEN;
                    end
                end
                RUN: begin
                    if (bus.PD_VLD) smp_q <= smp_q + 16'd1;
                end
                default: ;
            endcase

            // Error and DC estimate only move on valid samples while settling or adapting
            if ((state_q == SETTLE || state_q == RUN) && bus.PD_VLD) begin
                err_q    <= e;
                dc_acc_q <= dc_acc_q + ACC_W'(e);
            end
        end
    end

    assign bus.X_FRAC  = x_q;
    assign bus.OV      = ov_q;
    assign bus.CALI_EN = (state_q == RUN);
    assign bus.ERR     = err_q;
    assign bus.ERR_VLD = err_vld_q;
    assign bus.STATE   = state_q;
endmodule
